cache_nway_wb: RTL and testbench

- Parametrised set-associative, write-back, write-allocate data cache; next generation of the 2-way single-word-line cache.
- Sits between the CPU memory stage and main memory, with the same CPU-side and memory-side signal set.
- Adds configurable ways, sets and multi-word lines, word-serial burst refill and writeback, and invalid-first plus round-robin replacement.

---
 rtl/cache_nway_wb.sv | 235 +++++++++++++++++++++++
 tb/tb_cache_nway_wb.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cache_nway_wb.sv
// Set-associative write-back, write-allocate data cache with burst refill/writeback.
// Optional hit/miss/writeback counters enabled by defining CACHE_STATS_EN.
module cache_nway_wb #(
    parameter int NUM_SETS       = 64,
    parameter int NUM_WAYS       = 4,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  access_en,
    input  logic                  write_en,
    input  logic [1:0]            type_control,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  sign_ext,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  stall,
    output logic                  mem_write_en,
    output logic [1:0]            mem_type_control,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_sign_ext,
    input  logic [DATA_WIDTH-1:0] mem_dout
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]           stat_hits,
    output logic [31:0]           stat_misses,
    output logic [31:0]           stat_writebacks
`endif
);
    localparam int WL       = $clog2(WORDS_PER_LINE);
    localparam int OFF_BITS = WL + 2;
    localparam int IDX_BITS = $clog2(NUM_SETS);
    localparam int TAG_BITS = ADDR_WIDTH - IDX_BITS - OFF_BITS;
    localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int WC_W     = (WL > 0) ? WL : 1;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

    logic [DATA_WIDTH-1:0] data_q  [NUM_WAYS][NUM_SETS][WORDS_PER_LINE];
    logic [TAG_BITS-1:0]   tag_q   [NUM_WAYS][NUM_SETS];
    logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]   dirty_q [NUM_SETS];
    logic [WAY_W-1:0]      ptr_q   [NUM_SETS];

    state_t           state_q, state_d;
    logic [WC_W-1:0]  wcnt_q, wcnt_d;
    logic [WAY_W-1:0] vict_q, vict_d;
    logic             vinv_q, vinv_d;

    logic [TAG_BITS-1:0] req_tag;
    logic [IDX_BITS-1:0] idx;
    logic [WC_W-1:0]     woff;
    logic                hit, inv_found, last, miss, wb_start;
    logic [WAY_W-1:0]    hit_way, inv_way, ptr_nxt;
    logic                st_en, rf_en, fill_done;
    logic [31:0]         rd_word, rd_sh, wdata, merged;
    logic [3:0]          be;

    assign req_tag          = addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign idx              = addr[OFF_BITS +: IDX_BITS];
    assign woff             = WC_W'((addr >> 2) & ADDR_WIDTH'(WORDS_PER_LINE - 1));
    assign last             = (wcnt_q == WC_W'(WORDS_PER_LINE - 1));
    assign mem_type_control = 2'b10;
    assign mem_sign_ext     = 1'b0;
    assign ptr_nxt          = (NUM_WAYS == 1) ? '0 : ptr_q[idx] + 1'b1;

    function automatic logic [ADDR_WIDTH-1:0] line_addr(
        input logic [TAG_BITS-1:0] t,
        input logic [IDX_BITS-1:0] s,
        input logic [WC_W-1:0]     w
    );
        return (ADDR_WIDTH'(t) << (IDX_BITS + OFF_BITS))
             | (ADDR_WIDTH'(s) << OFF_BITS)
             | (ADDR_WIDTH'(w) << 2);
    endfunction

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[w][idx] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        rd_word = data_q[hit_way][idx][woff];
        rd_sh   = rd_word >> {addr[1:0], 3'b000};
        be      = 4'b1111;
        wdata   = din;
        unique case (type_control)
            2'b00: begin
                be    = 4'b0001 << addr[1:0];
                wdata = {4{din[7:0]}};
            end
            2'b01: begin
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{din[15:0]}};
            end
            default: ;
        endcase
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = be[b] ? wdata[8*b +: 8] : rd_word[8*b +: 8];
        end
    end

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        vict_d       = vict_q;
        vinv_d       = vinv_q;
        stall        = 1'b0;
        mem_write_en = 1'b0;
        mem_addr     = '0;
        mem_din      = '0;
        dout         = '0;
        st_en        = 1'b0;
        rf_en        = 1'b0;
        fill_done    = 1'b0;
        miss         = 1'b0;
        wb_start     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (access_en && hit) begin
                    st_en = write_en;
                    if (!write_en) begin
                        unique case (type_control)
                            2'b00:   dout = {{24{sign_ext & rd_sh[7]}}, rd_sh[7:0]};
                            2'b01:   dout = {{16{sign_ext & rd_sh[15]}}, rd_sh[15:0]};
                            default: dout = rd_sh;
                        endcase
                    end
                end else if (access_en) begin
                    stall    = 1'b1;
                    miss     = 1'b1;
                    vict_d   = inv_found ? inv_way : ptr_q[idx];
                    vinv_d   = inv_found;
                    wcnt_d   = '0;
                    wb_start = !inv_found && dirty_q[idx][ptr_q[idx]];
                    state_d  = wb_start ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                stall        = 1'b1;
                mem_write_en = 1'b1;
                mem_addr     = line_addr(tag_q[vict_q][idx], idx, wcnt_q);
                mem_din      = data_q[vict_q][idx][wcnt_q];
                wcnt_d       = last ? '0 : wcnt_q + 1'b1;
                if (last) state_d = REFILL;
            end
            REFILL: begin
                stall     = 1'b1;
                rf_en     = 1'b1;
                mem_addr  = line_addr(req_tag, idx, wcnt_q);
                fill_done = last;
                wcnt_d    = last ? '0 : wcnt_q + 1'b1;
                if (last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Data and tag arrays carry no reset; only the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (st_en) data_q[hit_way][idx][woff] <= merged;
            if (rf_en) data_q[vict_q][idx][wcnt_q] <= mem_dout;
            if (fill_done) tag_q[vict_q][idx] <= req_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            vict_q  <= '0;
            vinv_q  <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            vict_q  <= vict_d;
            vinv_q  <= vinv_d;
            if (st_en) dirty_q[idx][hit_way] <= 1'b1;
            if (fill_done) begin
                valid_q[idx][vict_q] <= 1'b1;
                dirty_q[idx][vict_q] <= 1'b0;
                if (!vinv_q) ptr_q[idx] <= ptr_nxt;
            end
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hits_q, hits_d, misses_q, misses_d, wbs_q, wbs_d;

    always_comb begin
        hits_d   = hits_q + 32'((state_q == IDLE) && access_en && hit && (hits_q != '1));
        misses_d = misses_q + 32'(miss && (misses_q != '1));
        wbs_d    = wbs_q + 32'(wb_start && (wbs_q != '1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hits_q   <= '0;
            misses_q <= '0;
            wbs_q    <= '0;
        end else begin
            hits_q   <= hits_d;
            misses_q <= misses_d;
            wbs_q    <= wbs_d;
        end
    end

    assign stat_hits       = hits_q;
    assign stat_misses     = misses_q;
    assign stat_writebacks = wbs_q;
`endif
endmodule

// File: tb/tb_cache_nway_wb.sv
// Directed bench for cache_nway_wb: refill, store merge, dirty eviction,
// round-robin replacement and mid-refill reset, against hand-computed values.
module tb_cache_nway_wb;
    logic        clk = 1'b0;
    logic        rst;
    logic        access_en, write_en, sign_ext;
    logic [1:0]  type_control;
    logic [31:0] addr, din, dout;
    logic        stall, mem_write_en, mem_sign_ext;
    logic [1:0]  mem_type_control;
    logic [31:0] mem_addr, mem_din, mem_dout;
`ifdef CACHE_STATS_EN
    logic [31:0] stat_hits, stat_misses, stat_writebacks;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int stall_cnt, wr_cnt;
    logic        done;
    logic [31:0] rd;
    logic [31:0] addr_log [40];
    logic [31:0] din_log  [40];

    always #5 clk = ~clk;

    // Memory content encodes the line tag (addr[25:10]) and the word number.
    assign mem_dout = {mem_addr[25:10], 16'h00A0} + {30'b0, mem_addr[3:2]};

    cache_nway_wb dut (
        .clk(clk), .rst(rst),
        .access_en(access_en), .write_en(write_en),
        .type_control(type_control), .addr(addr),
        .din(din), .sign_ext(sign_ext),
        .dout(dout), .stall(stall),
        .mem_write_en(mem_write_en),
        .mem_type_control(mem_type_control),
        .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_sign_ext(mem_sign_ext), .mem_dout(mem_dout)
`ifdef CACHE_STATS_EN
        ,
        .stat_hits(stat_hits),
        .stat_misses(stat_misses),
        .stat_writebacks(stat_writebacks)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic we, input logic [1:0] ty,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic se);
        access_en    = 1'b1;
        write_en     = we;
        type_control = ty;
        addr         = a;
        din          = d;
        sign_ext     = se;
        stall_cnt    = 0;
        wr_cnt       = 0;
        done         = 1'b0;
        rd           = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stall) begin
                rd   = dout;
                done = 1'b1;
                break;
            end
            addr_log[stall_cnt] = mem_addr;
            din_log[stall_cnt]  = mem_din;
            if (mem_write_en) wr_cnt++;
            stall_cnt++;
            @(posedge clk); #1;
        end
        chk("access_done", {31'b0, done}, 32'd1);
        @(posedge clk); #1;
        access_en = 1'b0;
        write_en  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        access_en = 1'b0; write_en = 1'b0; sign_ext = 1'b0;
        type_control = 2'b10; addr = '0; din = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_maddr", mem_addr, 32'd0);
        chk("rst_mwe", {31'b0, mem_write_en}, 32'd0);
        chk("rst_mdin", mem_din, 32'd0);
        chk("mem_type", {30'b0, mem_type_control}, 32'd2);
        chk("mem_sext", {31'b0, mem_sign_ext}, 32'd0);
        @(posedge clk); #1;

        access(1'b0, 2'b10, 32'h100, 32'h0, 1'b0);
        chk("s1_stall", stall_cnt, 5);
        for (int i = 0; i < 4; i++) chk("s1_addr", addr_log[i+1], 32'h100 + 4*i);
        chk("s1_dout", rd, 32'h0000_00A0);
        chk("s1_wr", wr_cnt, 0);

        access(1'b1, 2'b00, 32'h101, 32'h80, 1'b0);
        chk("s2_st_stall", stall_cnt, 0);
        chk("s2_st_wr", wr_cnt, 0);
        access(1'b0, 2'b00, 32'h101, 32'h0, 1'b1);
        chk("s2_lbs", rd, 32'hFFFF_FF80);
        chk("s2_lbs_stall", stall_cnt, 0);
        access(1'b0, 2'b00, 32'h101, 32'h0, 1'b0);
        chk("s2_lbu", rd, 32'h0000_0080);
        chk("s2_lbu_wr", wr_cnt, 0);
        access(1'b0, 2'b01, 32'h100, 32'h0, 1'b1);
        chk("s2_lhs", rd, 32'hFFFF_80A0);
        access(1'b0, 2'b01, 32'h100, 32'h0, 1'b0);
        chk("s2_lhu", rd, 32'h0000_80A0);

        access(1'b0, 2'b10, 32'h500, 32'h0, 1'b0);
        chk("s3_t1_stall", stall_cnt, 5);
        chk("s3_t1_dout", rd, 32'h0001_00A0);
        access(1'b0, 2'b10, 32'h900, 32'h0, 1'b0);
        chk("s3_t2_stall", stall_cnt, 5);
        access(1'b0, 2'b10, 32'hD00, 32'h0, 1'b0);
        chk("s3_t3_stall", stall_cnt, 5);
        access(1'b0, 2'b10, 32'h1100, 32'h0, 1'b0);
        chk("s3_t4_stall", stall_cnt, 9);
        chk("s3_t4_wr", wr_cnt, 4);
        for (int i = 0; i < 4; i++) chk("s3_wb_addr", addr_log[i+1], 32'h100 + 4*i);
        chk("s3_wb_d0", din_log[1], 32'h0000_80A0);
        chk("s3_wb_d1", din_log[2], 32'h0000_00A1);
        chk("s3_wb_d2", din_log[3], 32'h0000_00A2);
        chk("s3_wb_d3", din_log[4], 32'h0000_00A3);
        for (int i = 0; i < 4; i++) chk("s3_rf_addr", addr_log[i+5], 32'h1100 + 4*i);
        chk("s3_t4_dout", rd, 32'h0004_00A0);
`ifdef CACHE_STATS_EN
        chk("st_misses", stat_misses, 32'd5);
        chk("st_hits", stat_hits, 32'd10);
        chk("st_wbs", stat_writebacks, 32'd1);
`endif

        access(1'b0, 2'b10, 32'h1500, 32'h0, 1'b0);
        chk("s4_t5_stall", stall_cnt, 5);
        chk("s4_t5_wr", wr_cnt, 0);
        chk("s4_t5_dout", rd, 32'h0005_00A0);
        access(1'b0, 2'b10, 32'h900, 32'h0, 1'b0);
        chk("s4_w2_hit", stall_cnt, 0);
        access(1'b0, 2'b10, 32'h1900, 32'h0, 1'b0);
        chk("s4_t6_stall", stall_cnt, 5);
        chk("s4_t6_wr", wr_cnt, 0);
        access(1'b0, 2'b10, 32'hD00, 32'h0, 1'b0);
        chk("s4_w3_hit", stall_cnt, 0);
        access(1'b0, 2'b10, 32'h1100, 32'h0, 1'b0);
        chk("s4_w0_hit", stall_cnt, 0);
        access(1'b0, 2'b10, 32'h1500, 32'h0, 1'b0);
        chk("s4_w1_hit", stall_cnt, 0);
        access(1'b0, 2'b10, 32'h900, 32'h0, 1'b0);
        chk("s4_w2_evicted", stall_cnt, 5);
        chk("s4_w2_dout", rd, 32'h0002_00A0);

        access_en = 1'b1; write_en = 1'b0;
        type_control = 2'b10; addr = 32'h40;
        repeat (3) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("s5_pre_stall", {31'b0, stall}, 32'd1);
        chk("s5_pre_addr", mem_addr, 32'h48);
        rst = 1'b1;
        access_en = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("s5_rst_stall", {31'b0, stall}, 32'd0);
        chk("s5_rst_addr", mem_addr, 32'd0);
        chk("s5_rst_mwe", {31'b0, mem_write_en}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        access(1'b0, 2'b10, 32'h40, 32'h0, 1'b0);
        chk("s5_reload_stall", stall_cnt, 5);
        chk("s5_reload_dout", rd, 32'h0000_00A0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
